// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and its issue controller:
// opcode encodings, opcode classification helpers, flag bit positions
// and the issue FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD   = 4'd2;
    localparam logic [3:0] ALU_OP_SUB   = 4'd3;
    localparam logic [3:0] ALU_OP_AND   = 4'd4;
    localparam logic [3:0] ALU_OP_OR    = 4'd5;
    localparam logic [3:0] ALU_OP_XOR   = 4'd6;
    localparam logic [3:0] ALU_OP_NOT_A = 4'd7;

    // Bit positions inside the packed {CF,OF,SF,ZF} flag vector
    localparam int FLAG_CF = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_SF = 1;
    localparam int FLAG_ZF = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } issue_state_t;

    // Opcodes the ALU actually implements
    function automatic logic is_valid_op(input logic [3:0] op);
        return (op >= ALU_OP_ADD) && (op <= ALU_OP_NOT_A);
    endfunction

    // Opcodes whose carry/overflow flags are meaningful
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Storage is not reset; only pointers and the
// occupancy count are. The count is wide enough to tell full from empty,
// and pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [DEPTH-1:0] FULL_CNT = DEPTH'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; data path carries no reset
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + DEPTH'(1);
                2'b01:   count <= count - DEPTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit ALU. Commands are queued in a
// FIFO, issued one at a time on the ALU pins, and the registered result
// plus flags are handed back over a valid/ready response port.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       IN_OPCODE,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic [3:0]       RES_FLAGS,
    output logic             RES_ERR,
    output logic             BUSY
);

    localparam int ENTRY_W = 2 * WIDTH + 4;

    issue_state_t              state;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DEPTH-1:0]          fifo_count;
    logic [ENTRY_W-1:0]        head;
    logic [3:0]                head_op;
    logic signed [WIDTH-1:0]   head_a;
    logic signed [WIDTH-1:0]   head_b;

    // Carry and overflow carry no meaning for bitwise operations
    function automatic logic [3:0] mask_flags(input logic [3:0] op,
                                              input logic [3:0] raw);
        logic [3:0] f;
        f = raw;
        if (!is_arith_op(op)) begin
            f[FLAG_CF] = 1'b0;
            f[FLAG_OF] = 1'b0;
        end
        return f;
    endfunction

    assign IN_READY  = !fifo_full;
    assign fifo_push = IN_VALID && IN_READY;
    // Pop from IDLE, or straight out of RESP when the result is taken
    assign fifo_pop  = !fifo_empty &&
                       ((state == IDLE) || ((state == RESP) && RES_READY));
    assign head_op   = head[ENTRY_W-1 -: 4];
    assign head_a    = head[2*WIDTH-1 -: WIDTH];
    assign head_b    = head[WIDTH-1:0];
    assign BUSY      = (fifo_count != '0) || (state != IDLE);

    alu_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({IN_OPCODE, IN_A, IN_B}),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Issue FSM with registered ALU pins and response outputs; a pop
    // at the bottom overrides the per-state defaults
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            ALU_EN     <= 1'b0;
            ALU_OE     <= 1'b0;
            ALU_OPCODE <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            RES_VALID  <= 1'b0;
            RES_DATA   <= '0;
            RES_FLAGS  <= '0;
            RES_ERR    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ISSUE: begin
                    ALU_EN <= 1'b0;
                    ALU_OE <= 1'b1;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    ALU_OE    <= 1'b0;
                    RES_DATA  <= ALU_OUT;
                    RES_FLAGS <= mask_flags(ALU_OPCODE,
                                            {ALU_CF, ALU_OF, ALU_SF, ALU_ZF});
                    RES_ERR   <= 1'b0;
                    RES_VALID <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (RES_READY) begin
                        RES_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (fifo_pop) begin
                if (is_valid_op(head_op)) begin
                    ALU_OPCODE <= head_op;
                    ALU_A      <= head_a;
                    ALU_B      <= head_b;
                    ALU_EN     <= 1'b1;
                    state      <= ISSUE;
                end else begin
                    // Rejected without touching the ALU pins
                    RES_DATA   <= '0;
                    RES_FLAGS  <= '0;
                    RES_ERR    <= 1'b1;
                    RES_VALID  <= 1'b1;
                    state      <= RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU stub.
// The stub registers its result on EN and reports CF/OF combinationally
// from the live A/B/OPCODE pins (borrow-style CF on SUB, OF = CF ^ carry
// into the MSB, raw adder flags for every opcode).
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             CLK;
    logic             RST_N;
    logic             IN_VALID;
    logic             IN_READY;
    logic [3:0]       IN_OPCODE;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic             ALU_EN;
    logic             ALU_OE;
    logic [3:0]       ALU_OPCODE;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_OUT;
    logic             ALU_CF;
    logic             ALU_OF;
    logic             ALU_SF;
    logic             ALU_ZF;
    logic             RES_VALID;
    logic             RES_READY;
    logic [WIDTH-1:0] RES_DATA;
    logic [3:0]       RES_FLAGS;
    logic             RES_ERR;
    logic             BUSY;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_OPCODE  (IN_OPCODE),
        .IN_A       (IN_A),
        .IN_B       (IN_B),
        .ALU_EN     (ALU_EN),
        .ALU_OE     (ALU_OE),
        .ALU_OPCODE (ALU_OPCODE),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_OUT    (ALU_OUT),
        .ALU_CF     (ALU_CF),
        .ALU_OF     (ALU_OF),
        .ALU_SF     (ALU_SF),
        .ALU_ZF     (ALU_ZF),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .RES_DATA   (RES_DATA),
        .RES_FLAGS  (RES_FLAGS),
        .RES_ERR    (RES_ERR),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ALU stub
    logic [7:0] alu_q = 8'h00;
    logic [8:0] s9;
    logic [7:0] lo8;

    function automatic logic [7:0] alu_result(input logic [3:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        case (op)
            ALU_OP_ADD:   return a + b;
            ALU_OP_SUB:   return a - b;
            ALU_OP_AND:   return a & b;
            ALU_OP_OR:    return a | b;
            ALU_OP_XOR:   return a ^ b;
            ALU_OP_NOT_A: return ~a;
            default:      return 8'h00;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (ALU_EN) alu_q <= alu_result(ALU_OPCODE, ALU_A, ALU_B);
    end

    always_comb begin
        s9     = 9'd0;
        lo8    = 8'd0;
        ALU_CF = 1'b0;
        if (ALU_OPCODE == ALU_OP_SUB) begin
            s9     = {1'b0, ALU_A} + {1'b0, ~ALU_B} + 9'd1;
            lo8    = {1'b0, ALU_A[6:0]} + {1'b0, ~ALU_B[6:0]} + 8'd1;
            ALU_CF = ~s9[8];
        end else begin
            s9     = {1'b0, ALU_A} + {1'b0, ALU_B};
            lo8    = {1'b0, ALU_A[6:0]} + {1'b0, ALU_B[6:0]};
            ALU_CF = s9[8];
        end
        ALU_OF = ALU_CF ^ lo8[7];
    end

    assign ALU_OUT = alu_q;
    assign ALU_SF  = alu_q[7];
    assign ALU_ZF  = (alu_q == 8'h00);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        IN_VALID  = 1'b1;
        IN_OPCODE = op;
        IN_A      = a;
        IN_B      = b;
        tick();
        IN_VALID  = 1'b0;
    endtask

    // Push one command with RES_READY high and check its whole lifetime
    task automatic run_cmd(input string tag, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ed, input logic [3:0] ef,
                           input logic ee);
        int lat;
        int en_cnt;
        int oe_cnt;
        logic oe_ok;
        logic [3:0] op_seen;
        lat = 0; en_cnt = 0; oe_cnt = 0; oe_ok = 1'b1; op_seen = 4'h0;
        RES_READY = 1'b1;
        push(op, a, b);
        while (!RES_VALID && lat < 10) begin
            tick();
            lat++;
            if (ALU_EN) begin
                en_cnt++;
                op_seen = ALU_OPCODE;
            end
            if (ALU_OE) begin
                oe_cnt++;
                if (ALU_A !== a || ALU_B !== b || ALU_OPCODE !== op) oe_ok = 1'b0;
            end
        end
        chk({tag, "_valid"}, RES_VALID, 1);
        if (ee) begin
            chk({tag, "_lat_le2"}, (lat >= 1 && lat <= 2), 1);
            chk({tag, "_en_cnt"}, en_cnt, 0);
        end else begin
            chk({tag, "_lat"}, lat, 3);
            chk({tag, "_en_cnt"}, en_cnt, 1);
            chk({tag, "_oe_cnt"}, oe_cnt, 1);
            chk({tag, "_op"}, op_seen, op);
            chk({tag, "_held"}, oe_ok, 1);
        end
        chk({tag, "_data"}, RES_DATA, ed);
        chk({tag, "_flags"}, RES_FLAGS, ef);
        chk({tag, "_err"}, RES_ERR, ee);
        tick();
        chk({tag, "_done"}, RES_VALID, 0);
        chk({tag, "_idle"}, BUSY, 0);
    endtask

    initial begin
        int accepted;
        int n;
        int prev;
        int seen;
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_OPCODE = 4'h0;
        IN_A      = 8'h00;
        IN_B      = 8'h00;
        RES_READY = 1'b0;
        #12;
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_res_valid", RES_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_alu_en", ALU_EN, 0);
        chk("rst_alu_oe", ALU_OE, 0);
        chk("rst_res_data", RES_DATA, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        run_cmd("add", ALU_OP_ADD, 8'd100, 8'd50, 8'h96, 4'b0110, 1'b0);
        run_cmd("sub", ALU_OP_SUB, 8'd5, 8'd7, 8'hFE, 4'b1110, 1'b0);
        run_cmd("xor", ALU_OP_XOR, 8'h5A, 8'h5A, 8'h00, 4'b0001, 1'b0);
        run_cmd("not", ALU_OP_NOT_A, 8'h0F, 8'hF8, 8'hF0, 4'b0010, 1'b0);
        run_cmd("inv", 4'hF, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1);
        chk("inv_alu_a_held", ALU_A, 8'h0F);

        // Backpressure: FIFO plus one in flight
        RES_READY = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 8; c++) begin
            IN_VALID  = 1'b1;
            IN_OPCODE = ALU_OP_ADD;
            IN_A      = 8'(accepted + 1);
            IN_B      = 8'd10;
            if (IN_READY) accepted++;
            tick();
        end
        IN_VALID = 1'b0;
        chk("bp_accepted", accepted, 5);
        chk("bp_in_ready", IN_READY, 0);
        chk("bp_busy", BUSY, 1);
        chk("bp_res_valid", RES_VALID, 1);

        // Drain in order at one result per 3 cycles
        RES_READY = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!RES_VALID && n < 20) begin
                tick();
                n++;
            end
            chk("drain_valid", RES_VALID, 1);
            chk("drain_data", RES_DATA, 8'(11 + i));
            if (i > 0) chk("drain_gap", cyc - prev, 3);
            prev = cyc;
            tick();
        end
        chk("drain_idle", BUSY, 0);

        // Reset during CAPTURE with three commands queued
        RES_READY = 1'b0;
        for (int c = 0; c < 4; c++) push(ALU_OP_OR, 8'(c), 8'h40);
        chk("mr_first_resp", RES_VALID, 1);
        RES_READY = 1'b1;
        push(ALU_OP_OR, 8'h09, 8'h40);
        RES_READY = 1'b0;
        tick();
        chk("mr_in_capture", ALU_OE, 1);
        RST_N = 1'b0;
        #1;
        chk("mr_in_ready", IN_READY, 1);
        chk("mr_busy", BUSY, 0);
        chk("mr_alu_oe", ALU_OE, 0);
        chk("mr_alu_en", ALU_EN, 0);
        chk("mr_res_valid", RES_VALID, 0);
        chk("mr_alu_a", ALU_A, 0);
        chk("mr_res_data", RES_DATA, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        RES_READY = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (RES_VALID || BUSY) seen++;
        end
        chk("mr_quiet", seen, 0);
        run_cmd("and", ALU_OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
